// File: rtl/contadores_pkg.sv
// Shared constants, select-width helper and read-FSM encoding for the pop counter bank.
package contadores_pkg;

   localparam int unsigned NUM_CH_DEF = 4;
   localparam int unsigned CNT_W_DEF  = 5;
   localparam int unsigned DATA_W     = 10;

   // Ceil(log2(n)), never below 1 so a select port always has at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) r = unsigned'(i + 1);
      end
      return r;
   endfunction

   typedef enum logic {
      IDLE_ST,
      HOLD_ST
   } rd_state_e;

endpackage

// File: rtl/contador_canal.sv
// One channel pop counter with wrap/saturate behaviour, sticky overflow and clear-on-read.
module contador_canal
   import contadores_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             overflow
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             wrap;

   always_comb begin
      wrap  = inc & (&cnt_q);
      cnt_d = cnt_q;
      if (clr) begin
         // Pop arriving in the read cycle is not lost: it becomes the first new count.
         cnt_d = inc ? CNT_W'(1) : '0;
      end else if (inc) begin
         cnt_d = (wrap && SATURATE) ? cnt_q : cnt_q + CNT_W'(1);
      end
      // A fresh overflow on the clearing edge must survive the clear.
      ovf_d = wrap ? 1'b1 : (clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt      = cnt_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/contadores_param.sv
// Parametrised per-channel pop counter bank with an idle-gated request/valid readout.
module contadores_param
   import contadores_pkg::*;
#(
   parameter int unsigned NUM_CH        = NUM_CH_DEF,
   parameter int unsigned SEL_W         = clog2(NUM_CH),
   parameter int unsigned CNT_W         = CNT_W_DEF,
   parameter bit          SATURATE      = 1'b0,
   parameter bit          CLEAR_ON_READ = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] pop,
   input  logic              idle,
   input  logic              request,
   input  logic [SEL_W-1:0]  select,
   output logic [CNT_W-1:0]  contador,
   output logic              valid,
   output logic              pending,
   output logic [NUM_CH-1:0] overflow
);

   rd_state_e        state_q, state_d;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] srv_sel;
   logic             act;
   logic             serve;
   logic [CNT_W-1:0] rd_val;
   logic [NUM_CH-1:0] clr;
   logic [CNT_W-1:0] cnt [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      contador_canal #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_canal (
         .clk      (clk),
         .reset    (reset),
         .inc      (pop[i]),
         .clr      (clr[i]),
         .cnt      (cnt[i]),
         .overflow (overflow[i])
      );
   end

   // A new request overrides any held one, and is served at once if idle is already high.
   always_comb begin
      act     = request | (state_q == HOLD_ST);
      serve   = act & idle;
      srv_sel = request ? select : sel_q;

      state_d = state_q;
      unique case (state_q)
         IDLE_ST: if (request && !idle) state_d = HOLD_ST;
         HOLD_ST: if (idle) state_d = IDLE_ST;
         default: state_d = IDLE_ST;
      endcase
   end

   // Out-of-range selects match no channel: they read 0 and clear nothing.
   always_comb begin
      rd_val = '0;
      clr    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (32'(srv_sel) == i) begin
            rd_val = cnt[i];
            clr[i] = CLEAR_ON_READ & serve;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE_ST;
         sel_q    <= '0;
         valid    <= 1'b0;
         contador <= '0;
      end else begin
         state_q <= state_d;
         if (request) sel_q <= select;
         valid <= serve;
         if (serve) contador <= rd_val;
      end
   end

   assign pending = (state_q == HOLD_ST);

endmodule

// File: tb/tb_contadores_param.sv
// Four differently configured counter banks against a per-cycle behavioural model.
module tb_contadores_param;

   localparam int NCH [4] = '{4, 3, 4, 4};
   localparam int CW  [4] = '{5, 3, 3, 5};
   localparam int SAT [4] = '{0, 1, 0, 1};
   localparam int COR [4] = '{1, 0, 1, 1};

   logic       clk = 1'b0;
   logic       reset, idle, request;
   logic [3:0] pop;
   logic [1:0] select;

   logic [4:0] cont_a, cont_d;
   logic [2:0] cont_b, cont_c;
   logic       valid_a, valid_b, valid_c, valid_d;
   logic       pend_a, pend_b, pend_c, pend_d;
   logic [3:0] ovf_a, ovf_c, ovf_d;
   logic [2:0] ovf_b;

   logic [31:0] g_cnt [4];
   logic [31:0] g_vld [4];
   logic [31:0] g_pnd [4];
   logic [31:0] g_ovf [4];

   int total = 0;
   int bad   = 0;

   int m_cnt [4][4];
   bit m_ovf [4][4];
   bit m_held [4];
   int m_sel [4];
   bit m_vld [4];
   int m_out [4];

   always #5 clk = ~clk;

   contadores_param u_dut_a (
      .clk(clk), .reset(reset), .pop(pop), .idle(idle), .request(request), .select(select),
      .contador(cont_a), .valid(valid_a), .pending(pend_a), .overflow(ovf_a)
   );

   contadores_param #(
      .NUM_CH(3), .CNT_W(3), .SATURATE(1'b1), .CLEAR_ON_READ(1'b0)
   ) u_dut_b (
      .clk(clk), .reset(reset), .pop(pop[2:0]), .idle(idle), .request(request),
      .select(select), .contador(cont_b), .valid(valid_b), .pending(pend_b), .overflow(ovf_b)
   );

   contadores_param #(
      .NUM_CH(4), .CNT_W(3), .SATURATE(1'b0), .CLEAR_ON_READ(1'b1)
   ) u_dut_c (
      .clk(clk), .reset(reset), .pop(pop), .idle(idle), .request(request), .select(select),
      .contador(cont_c), .valid(valid_c), .pending(pend_c), .overflow(ovf_c)
   );

   contadores_param #(
      .NUM_CH(4), .CNT_W(5), .SATURATE(1'b1), .CLEAR_ON_READ(1'b1)
   ) u_dut_d (
      .clk(clk), .reset(reset), .pop(pop), .idle(idle), .request(request), .select(select),
      .contador(cont_d), .valid(valid_d), .pending(pend_d), .overflow(ovf_d)
   );

   assign g_cnt[0] = 32'(cont_a);
   assign g_cnt[1] = 32'(cont_b);
   assign g_cnt[2] = 32'(cont_c);
   assign g_cnt[3] = 32'(cont_d);
   assign g_vld[0] = 32'(valid_a);
   assign g_vld[1] = 32'(valid_b);
   assign g_vld[2] = 32'(valid_c);
   assign g_vld[3] = 32'(valid_d);
   assign g_pnd[0] = 32'(pend_a);
   assign g_pnd[1] = 32'(pend_b);
   assign g_pnd[2] = 32'(pend_c);
   assign g_pnd[3] = 32'(pend_d);
   assign g_ovf[0] = 32'(ovf_a);
   assign g_ovf[1] = 32'(ovf_b);
   assign g_ovf[2] = 32'(ovf_c);
   assign g_ovf[3] = 32'(ovf_d);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the bank described directly from its counting and readout rules.
   task automatic model_step();
      for (int d = 0; d < 4; d++) begin
         int n, mx, sel;
         bit act, serve, p, ev;
         n  = NCH[d];
         mx = (1 << CW[d]) - 1;
         if (reset) begin
            for (int ch = 0; ch < 4; ch++) begin
               m_cnt[d][ch] = 0;
               m_ovf[d][ch] = 1'b0;
            end
            m_held[d] = 1'b0;
            m_sel[d]  = 0;
            m_vld[d]  = 1'b0;
            m_out[d]  = 0;
         end else begin
            act   = request || m_held[d];
            sel   = request ? int'(select) : m_sel[d];
            serve = act && idle;
            m_vld[d] = serve;
            if (serve) m_out[d] = (sel < n) ? m_cnt[d][sel] : 0;
            for (int ch = 0; ch < n; ch++) begin
               p  = pop[ch];
               ev = p && (m_cnt[d][ch] == mx);
               if (ev) begin
                  m_ovf[d][ch] = 1'b1;
                  m_cnt[d][ch] = (SAT[d] == 1) ? mx : 0;
               end else begin
                  m_cnt[d][ch] = m_cnt[d][ch] + int'(p);
               end
               if (serve && COR[d] == 1 && sel == ch) begin
                  m_cnt[d][ch] = int'(p);
                  m_ovf[d][ch] = ev;
               end
            end
            m_held[d] = act && !idle;
            if (request) m_sel[d] = int'(select);
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 4; d++) begin
         logic [31:0] e_ovf;
         e_ovf = '0;
         for (int ch = 0; ch < NCH[d]; ch++) e_ovf[ch] = m_ovf[d][ch];
         check_eq($sformatf("d%0d_valid", d), g_vld[d], 32'(m_vld[d]));
         check_eq($sformatf("d%0d_pending", d), g_pnd[d], 32'(m_held[d]));
         check_eq($sformatf("d%0d_contador", d), g_cnt[d], 32'(m_out[d]));
         check_eq($sformatf("d%0d_overflow", d), g_ovf[d], e_ovf);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int pop_pct, req_pct;
      reset   = 1'b1;
      pop     = '0;
      idle    = 1'b1;
      request = 1'b0;
      select  = '0;
      @(negedge clk);
      step();
      step();
      check_eq("rst_valid", g_vld[0], 32'd0);
      check_eq("rst_overflow", g_ovf[0], 32'd0);
      reset = 1'b0;

      // Counting and clear-on-read.
      pop = 4'b0001;
      step();
      step();
      pop = 4'b0101;
      step();
      pop = '0;
      request = 1'b1;
      select  = 2'd0;
      step();
      check_eq("plan_rd0_valid", g_vld[0], 32'd1);
      check_eq("plan_rd0", g_cnt[0], 32'd3);
      select = 2'd2;
      step();
      check_eq("plan_rd2", g_cnt[0], 32'd1);
      select = 2'd0;
      step();
      check_eq("plan_rerd0", g_cnt[0], 32'd0);
      request = 1'b0;
      step();

      // Idle gating with a replacing request.
      idle    = 1'b0;
      request = 1'b1;
      select  = 2'd1;
      step();
      request = 1'b0;
      check_eq("plan_pending", g_pnd[0], 32'd1);
      step();
      step();
      request = 1'b1;
      select  = 2'd3;
      step();
      request = 1'b0;
      step();
      idle = 1'b1;
      step();
      check_eq("plan_pend_clr", g_pnd[0], 32'd0);
      check_eq("plan_late_valid", g_vld[0], 32'd1);
      step();

      // Wrap on the 3-bit wrapping bank and saturation on the 5-bit saturating bank.
      pop = 4'b0010;
      repeat (9) step();
      pop = '0;
      check_eq("plan_wrap_ovf", 32'(g_ovf[2][1]), 32'd1);
      request = 1'b1;
      select  = 2'd1;
      step();
      request = 1'b0;
      check_eq("plan_wrap_rd", g_cnt[2], 32'd1);
      check_eq("plan_wrap_ovf_clr", 32'(g_ovf[2][1]), 32'd0);
      pop = 4'b1000;
      repeat (40) step();
      pop = '0;
      check_eq("plan_sat_ovf", 32'(g_ovf[3][3]), 32'd1);
      request = 1'b1;
      select  = 2'd3;
      step();
      request = 1'b0;
      check_eq("plan_sat_rd", g_cnt[3], 32'd31);
      check_eq("plan_sat_ovf_clr", 32'(g_ovf[3][3]), 32'd0);

      // Pop in the service cycle, then all channels together.
      pop = 4'b0001;
      repeat (5) step();
      request = 1'b1;
      select  = 2'd0;
      step();
      check_eq("plan_simul_rd", g_cnt[0], 32'd5);
      pop = '0;
      step();
      check_eq("plan_simul_rerd", g_cnt[0], 32'd1);
      request = 1'b0;
      pop = 4'hf;
      repeat (6) step();
      pop = '0;
      request = 1'b1;
      for (int i = 0; i < 4; i++) begin
         select = 2'(i);
         step();
         check_eq($sformatf("plan_all_rd%0d", i), g_cnt[0], 32'd6);
         check_eq($sformatf("plan_all_vld%0d", i), g_vld[0], 32'd1);
      end
      request = 1'b0;
      step();

      // Reset discards a held request; out-of-range select reads zero.
      pop = 4'b0001;
      step();
      step();
      pop = '0;
      idle    = 1'b0;
      request = 1'b1;
      select  = 2'd0;
      step();
      request = 1'b0;
      reset   = 1'b1;
      step();
      reset = 1'b0;
      idle  = 1'b1;
      step();
      check_eq("plan_rst_novalid", g_vld[0], 32'd0);
      check_eq("plan_rst_nopend", g_pnd[0], 32'd0);
      pop = 4'b0001;
      step();
      step();
      pop = '0;
      request = 1'b1;
      select  = 2'd0;
      step();
      check_eq("plan_b_rd0", g_cnt[1], 32'd2);
      select = 2'd3;
      step();
      check_eq("plan_badsel_vld", g_vld[1], 32'd1);
      check_eq("plan_badsel_rd", g_cnt[1], 32'd0);
      select = 2'd0;
      step();
      check_eq("plan_badsel_keep", g_cnt[1], 32'd2);
      request = 1'b0;
      step();

      // Randomized epochs alternating busy/quiet readout and light/heavy popping.
      for (int e = 0; e < 16; e++) begin
         pop_pct = (e % 3 == 0) ? 90 : 50;
         req_pct = (e % 2 == 1) ? 25 : 3;
         repeat (200) begin
            reset   = ($urandom_range(999) < 5);
            idle    = ($urandom_range(99) < 70);
            request = ($urandom_range(99) < req_pct);
            select  = 2'($urandom_range(3));
            for (int b = 0; b < 4; b++) pop[b] = ($urandom_range(99) < pop_pct);
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
